pc_sequencer: RTL

Parametrised instruction-fetch sequencer for the MIPS cores. It replaces the free-running PC register, PC adders and PC-source mux of the single-cycle datapath with a state machine. The state machine adds a variable-latency instruction-memory handshake, core back-pressure (stall), halt/resume, an invalid-instruction trap and a retired-instruction counter. It sits between the instruction memory and the decode/execute logic and owns the architectural PC.

---
 rtl/pc_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the architectural PC, runs the imem handshake,
// and handles stall, halt/resume, invalid-instruction trap and retire counting.
module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter int                INST_W    = 32,
  parameter int                PC_STEP   = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = '0,
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  input  logic              stall,
  input  logic [1:0]        pc_src,
  input  logic [ADDR_W-1:0] branch_off,
  input  logic [ADDR_W-1:0] target,
  input  logic              invalid,
  input  logic              halt_req,
  input  logic              resume,
  output logic              halted,
  output logic              trapped,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {BOOT, REQ, EXEC, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] next_pc;

  // Handshake outputs are pure decodes of registered state, so imem_ack never
  // reaches imem_req/imem_addr combinationally.
  assign imem_req   = (state == REQ);
  assign imem_addr  = pc;
  assign inst_valid = (state == EXEC);
  assign halted     = (state == HALT);
  assign pc_plus    = pc + ADDR_W'(PC_STEP);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_pc = pc_plus;
    if (invalid) begin
      next_pc = TRAP_VEC;
    end else begin
      unique case (pc_src)
        2'b01:   next_pc = pc_plus + branch_off;
        2'b10,
        2'b11:   next_pc = target;
        default: next_pc = pc_plus;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= BOOT;
      pc      <= RESET_VEC;
      inst    <= '0;
      retired <= '0;
      trapped <= 1'b0;
    end else begin
      unique case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (imem_ack) begin
            inst  <= imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc <= next_pc;
            if (invalid) trapped <= 1'b1;
            else         retired <= retired + CNT_W'(1);
            state <= halt_req ? HALT : REQ;
          end
        end
        HALT: begin
          if (resume) state <= REQ;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
